// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle RV32 subset control path.
//   - state_t     : FSM state encodings (IDLE..HALT; 7 is unreachable)
//   - OP_*        : supported major opcodes (IR[6:0])
//   - ALU_*       : alu_op encodings driven to the ALU decoder
//   - F3_BEQ/BNE  : supported branch funct3 values
//   - is_supported: decode-time legality check of opcode/funct3
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Branches are only legal for BEQ/BNE; every other supported opcode is
    // legal regardless of funct3 because the ALU decoder owns funct3 there.
    function automatic logic is_supported(input logic [6:0] opcode,
                                          input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE: ok = 1'b1;
            OP_BRANCH: ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// Counts cycles in which a memory request is pending without completion and
// flags the cycle in which the pending request would exceed MEM_TIMEOUT.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   clr    in  clear count (held while not in an access state)
//   en     in  request pending and not ready this cycle
//   expire out this is the MEM_TIMEOUT-th consecutive unserved request cycle
// ---------------------------------------------------------------------------
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Count unserved request cycles; clearing outside the access states
    // guarantees the count starts at zero on every entry to FETCH or MEM.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // The count lags the current cycle by one, so comparing against
    // MEM_TIMEOUT-1 fires on exactly the MEM_TIMEOUT-th unserved cycle.
    // A ready in that same cycle drops en and therefore wins.
    assign expire = en && (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multi-cycle RV32 subset core: sequences fetch, decode,
// execute, memory and writeback over a shared single-port memory and drives
// every datapath enable/select.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   run               permits starting a new instruction
//   opcode, funct3    IR[6:0], IR[14:12]
//   alu_zero          ALU result == 0
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_we   memory request / store strobe
//   addr_sel          0 = PC, 1 = ALU result
//   ir_we             load IR (Mealy on mem_ready in FETCH)
//   pc_we, pc_src     PC update, 0 = PC+4, 1 = PC+imm
//   alu_src_imm       ALU operand B = immediate
//   alu_op            00 add, 01 sub, 10 funct-decoded
//   rf_we, wb_sel     regfile write, 0 = ALU, 1 = memory data
//   state             current state encoding
//   illegal, timeout  sticky error flags
//   retired           one-cycle pulse per completed instruction
// Optional macro MULTICYCLE_PERF_EN adds instret[31:0] and cycles[31:0].
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic        retired
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] cycles
`endif
);

    state_t state_r;
    state_t state_nxt;
    logic   set_illegal;
    logic   set_timeout;
    logic   in_access;
    logic   expire;

    assign state = state_r;

    // The request is a pure decode of the access states, kept outside the
    // main comb block so the timeout counter can use it without a loop
    // through the next-state logic. Reset masks it so an in-flight access
    // is abandoned the moment rst is seen.
    assign in_access = (state_r == S_FETCH) || (state_r == S_MEM);
    assign mem_req   = in_access && !rst;

    mem_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_access),
        .en     (mem_req && !mem_ready),
        .expire (expire)
    );

    // State register; reset returns to IDLE regardless of any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Sticky error flags, only cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
        end
    end

    // Next-state and strobe decode. Strobes are Moore decodes of state and
    // opcode, except ir_we and the store retire which must qualify on
    // mem_ready so they fire exactly once per access. Everything is forced
    // low while rst is high so no PC/regfile write escapes an aborted cycle.
    always_comb begin
        state_nxt   = state_r;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        retired     = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end

            S_FETCH: begin
                addr_sel = 1'b0;
                ir_we    = mem_ready;
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (expire) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end
            end

            S_DECODE: begin
                if (is_supported(opcode, funct3)) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt   = S_HALT;
                    set_illegal = 1'b1;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op      = ALU_FUNCT;
                        alu_src_imm = 1'b0;
                        state_nxt   = S_WB;
                    end
                    OP_I: begin
                        alu_op      = ALU_FUNCT;
                        alu_src_imm = 1'b1;
                        state_nxt   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                        state_nxt   = S_MEM;
                    end
                    OP_BRANCH: begin
                        // The ALU subtracts rs1-rs2; zero means equal, so
                        // BEQ takes the branch on zero and BNE on non-zero.
                        alu_op      = ALU_SUB;
                        alu_src_imm = 1'b0;
                        pc_we       = 1'b1;
                        pc_src      = (funct3 == F3_BEQ) ? alu_zero : !alu_zero;
                        retired     = 1'b1;
                        state_nxt   = run ? S_FETCH : S_IDLE;
                    end
                    default: begin
                        // The IR changed under us after decode; treat as illegal.
                        state_nxt   = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we     = 1'b1;
                        pc_src    = 1'b0;
                        retired   = 1'b1;
                        state_nxt = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (expire) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end
            end

            S_WB: begin
                rf_we     = 1'b1;
                wb_sel    = (opcode == OP_LOAD);
                pc_we     = 1'b1;
                pc_src    = 1'b0;
                retired   = 1'b1;
                state_nxt = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                // Encoding 7 can only appear through an upset; park safely.
                state_nxt   = S_HALT;
                set_illegal = 1'b1;
            end
        endcase

        if (rst) begin
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 1'b0;
            alu_src_imm = 1'b0;
            alu_op      = ALU_ADD;
            rf_we       = 1'b0;
            wb_sel      = 1'b0;
            retired     = 1'b0;
        end
    end

`ifdef MULTICYCLE_PERF_EN
    // Performance counters: retired instructions and non-halted cycles,
    // both free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (retired) instret <= instret + 32'd1;
            if (state_r != S_HALT) cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each test walks an instruction through
// the FSM cycle by cycle against hand-computed state/strobe vectors.
// Observed vector layout: {illegal, timeout, state[2:0], strobes[11:0]} with
// strobes = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_imm,
//            alu_op[1:0], rf_we, wb_sel, retired}.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic        alu_src_imm, rf_we, wb_sel, illegal, timeout, retired;
    logic [1:0]  alu_op;
    logic [2:0]  state;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] instret, cycles;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [11:0] strobes;
    logic [16:0] obs;
    assign strobes = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
                      alu_src_imm, alu_op, rf_we, wb_sel, retired};
    assign obs = {illegal, timeout, state, strobes};

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .funct3      (funct3),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .state       (state),
        .illegal     (illegal),
        .timeout     (timeout),
        .retired     (retired)
`ifdef MULTICYCLE_PERF_EN
        ,
        .instret     (instret),
        .cycles      (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled two time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; opcode = 7'd0; funct3 = 3'd0;
        alu_zero = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        #2;
        vectors++;
        if (obs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b, want %b", obs, 17'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        logic [16:0] exp [0:4];
        logic        rdy [0:3];
        logic        rn  [0:3];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_0011_0000},
                {2'b00, 3'd5, 12'b0000_1000_0101},
                {2'b00, 3'd0, 12'b0000_0000_0000}};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
        rn  = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 7'b0010011; funct3 = 3'b000; run = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                mem_ready = rdy[i];
                run       = rn[i];
            end else begin
                mem_ready = 1'b0;
            end
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL addi_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp [0:6];
        logic        rdy [0:5];
        logic        rn  [0:5];
        logic [2:0]  f3  [0:5];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_1100_1001},
                {2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_1000_1001},
                {2'b00, 3'd0, 12'b0000_0000_0000}};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rn  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        f3  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
        opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1; run = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                mem_ready = rdy[i];
                run       = rn[i];
                funct3    = f3[i];
            end else begin
                mem_ready = 1'b0;
            end
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL branch_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_load();
        logic [16:0] exp [0:11];
        logic        rdy [0:10];
        exp = '{{2'b00, 3'd1, 12'b1000_0000_0000},
                {2'b00, 3'd1, 12'b1000_0000_0000},
                {2'b00, 3'd1, 12'b1000_0000_0000},
                {2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_0010_0000},
                {2'b00, 3'd4, 12'b1010_0000_0000},
                {2'b00, 3'd4, 12'b1010_0000_0000},
                {2'b00, 3'd4, 12'b1010_0000_0000},
                {2'b00, 3'd4, 12'b1010_0000_0000},
                {2'b00, 3'd5, 12'b0000_1000_0111},
                {2'b00, 3'd0, 12'b0000_0000_0000}};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0000011; funct3 = 3'b010; run = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            mem_ready = (i < 11) ? rdy[i] : 1'b0;
            run       = (i < 10);
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL load_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_store();
        logic [16:0] exp [0:5];
        logic        rdy [0:4];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_0010_0000},
                {2'b00, 3'd4, 12'b1110_0000_0000},
                {2'b00, 3'd4, 12'b1110_1000_0001},
                {2'b00, 3'd0, 12'b0000_0000_0000}};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 7'b0100011; funct3 = 3'b010; run = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i < 5) ? rdy[i] : 1'b0;
            run       = (i < 4);
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL store_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [16:0] halted;
        halted = {2'b01, 3'd6, 12'b0000_0000_0000};
        opcode = 7'b0010011; funct3 = 3'b000; run = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            #2;
            vectors++;
            if ({state, mem_req, timeout} !== {3'd1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL timeout_req%0d: got state=%0d req=%b to=%b, want state=1 req=1 to=0",
                         i + 1, state, mem_req, timeout);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if (obs !== halted) begin
                miscompares++;
                $display("[TB] FAIL timeout_halt%0d: got %b, want %b", i, obs, halted);
            end
            tick();
        end
    endtask

    task automatic test_ready_at_limit();
        logic [16:0] exp [0:4];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_0011_0000},
                {2'b00, 3'd5, 12'b0000_1000_0101},
                {2'b00, 3'd0, 12'b0000_0000_0000}};
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        vectors++;
        if (obs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL limit_reset_clear: got %b, want %b", obs, 17'd0);
        end
        opcode = 7'b0010011; funct3 = 3'b000; run = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            #2;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 0);
            run       = (i < 3);
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL limit_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [16:0] exp [0:3];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b10, 3'd6, 12'b0000_0000_0000},
                {2'b10, 3'd6, 12'b0000_0000_0000}};
        opcode = 7'b1111111; funct3 = 3'b000; run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL illegal_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        logic [16:0] exp [0:3];
        exp = '{{2'b00, 3'd1, 12'b1001_0000_0000},
                {2'b00, 3'd2, 12'b0000_0000_0000},
                {2'b00, 3'd3, 12'b0000_0010_0000},
                {2'b00, 3'd4, 12'b1110_0000_0000}};
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        vectors++;
        if (obs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_clears_illegal: got %b, want %b", obs, 17'd0);
        end
        opcode = 7'b0100011; funct3 = 3'b010; run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #2;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL rstmem_cycle%0d: got %b, want %b", i, obs, exp[i]);
            end
            tick();
        end
        // Store completes this cycle, but reset must suppress the retire.
        rst = 1'b1; mem_ready = 1'b1; run = 1'b0;
        #2;
        vectors++;
        if ({illegal, timeout, strobes} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_abort_strobes: got %b, want %b",
                     {illegal, timeout, strobes}, 14'd0);
        end
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if (obs !== 17'd0) begin
                miscompares++;
                $display("[TB] FAIL rst_idle_hold%0d: got %b, want %b", i, obs, 17'd0);
            end
            tick();
        end
    endtask

    // Bound the whole run in case the DUT or bench stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load();
        test_store();
        test_timeout();
        test_ready_at_limit();
        test_illegal();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
